// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and helpers for the streaming Sobel core.
//   DEF_PIX_W : default pixel width the typedefs are sized from; instances with another
//               pixel width declare local grad_t/mag_t typedefs of the same shape.
//   grad_t    : signed gradient, PIX_W+3 bits (holds +/-4*(2^PIX_W-1) without overflow).
//   mag_t     : unsigned |Gx|+|Gy|, PIX_W+4 bits.
//   abs_grad  : absolute value of a sign-extended gradient.
//   sat_pix   : clamp a magnitude to the largest value representable in pix_w bits.
package sobel_pkg;

    localparam int unsigned DEF_PIX_W = 8;

    typedef logic signed [DEF_PIX_W+2:0] grad_t;
    typedef logic        [DEF_PIX_W+3:0] mag_t;

    // Operates on 32-bit values so any instance pixel width up to ~28 bits can share it.
    function automatic logic [31:0] abs_grad(input logic signed [31:0] g);
        return g[31] ? $unsigned(-g) : $unsigned(g);
    endfunction

    function automatic logic [31:0] sat_pix(input logic [31:0] mag, input int unsigned pix_w);
        logic [31:0] max_v;
        max_v = (32'd1 << pix_w) - 32'd1;
        return (mag > max_v) ? max_v : mag;
    endfunction

endpackage

// File: rtl/sobel_stream_core_if.sv
// sobel_stream_core_if: pixel-in / magnitude-out stream bundle.
//   s_valid/s_ready/s_data           : input pixel stream (raster order)
//   m_valid/m_ready/m_data/m_last/m_eof : output stream with line and frame markers
// Modports: slave = the core's view, master = the source/sink driving the core.
interface sobel_stream_core_if
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_last;
    logic             m_eof;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last, m_eof
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_eof
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two IMG_W-deep line stores holding rows row-1 and row-2.
//   clk     : clock
//   i_we    : write enable (one accepted pixel)
//   i_addr  : current column
//   i_data  : incoming pixel, written into the row-1 store
//   o_row1  : stored pixel of row-1 at i_addr
//   o_row2  : stored pixel of row-2 at i_addr
// On a write the old row-1 entry moves down into row-2 at the same column, so the two
// stores roll forward one line per input line. Contents are not reset.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 100,
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W-1:0] o_row1,
    output logic [PIX_W-1:0] o_row2
);

    logic [PIX_W-1:0] r_row1 [IMG_W];
    logic [PIX_W-1:0] r_row2 [IMG_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_row1[i_addr] <= i_data;
            r_row2[i_addr] <= r_row1[i_addr];
        end
    end

    assign o_row1 = r_row1[i_addr];
    assign o_row2 = r_row2[i_addr];

endmodule

// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel edge detector, output = |Gx|+|Gy| per interior pixel.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   thresh : binary edge threshold (only used with SOBEL_THRESH_EN)
//   bus    : sobel_stream_core_if.slave, input pixels in / magnitudes out
// Build option: define SOBEL_THRESH_EN to emit binary edges (mag >= thresh -> all ones, else 0)
// instead of the saturated magnitude.
// Pipeline: window register (shifted on accept) -> stage 1 Gx/Gy -> stage 2 output. Every
// stage advances on en = !m_valid | m_ready, so a stalled output freezes the whole core.
module sobel_stream_core
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 100,
    parameter int unsigned IMG_H = 100,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] thresh,
    sobel_stream_core_if.slave bus
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Per-instance widths shadow the package defaults.
    typedef logic signed [PIX_W+2:0] grad_t;
    typedef logic        [PIX_W+3:0] mag_t;
    typedef logic        [PIX_W-1:0] pix_t;

    function automatic grad_t ext(input pix_t p);
        return grad_t'({3'b000, p});
    endfunction

    logic             w_en;
    logic             w_acc;
    logic             w_col_last;
    logic             w_row_last;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    pix_t             w_lb_row1;
    pix_t             w_lb_row2;

    // [row][col]: row 0 = oldest line (r-2), col 2 = most recent column.
    logic [2:0][2:0][PIX_W-1:0] r_win;
    logic             r_v0;
    logic             r_last0;
    logic             r_eof0;

    grad_t            w_gx;
    grad_t            w_gy;
    grad_t            r_gx;
    grad_t            r_gy;
    logic             r_v1;
    logic             r_last1;
    logic             r_eof1;

    mag_t             w_mag;
    pix_t             w_pix;
    logic             r_m_valid;
    pix_t             r_m_data;
    logic             r_m_last;
    logic             r_m_eof;

    assign w_en       = !r_m_valid | bus.m_ready;
    assign w_acc      = bus.s_valid & w_en;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));

    // Raster position of the next accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk    (clk),
        .i_we   (w_acc),
        .i_addr (r_col),
        .i_data (bus.s_data),
        .o_row1 (w_lb_row1),
        .o_row2 (w_lb_row2)
    );

    // Window shifts only on a real transfer; the valid bit tracks whether that transfer
    // completed an interior 3x3 neighbourhood (line-wrap positions are dropped here).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_v0    <= 1'b0;
            r_last0 <= 1'b0;
            r_eof0  <= 1'b0;
        end else if (w_en) begin
            if (w_acc) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb_row2;
                r_win[1][2] <= w_lb_row1;
                r_win[2][2] <= bus.s_data;
            end
            r_v0    <= w_acc & (r_row >= RW'(2)) & (r_col >= CW'(2));
            r_last0 <= w_col_last;
            r_eof0  <= w_col_last & w_row_last;
        end
    end

    assign w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
                - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
    assign w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
                - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gx    <= '0;
            r_gy    <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_eof1  <= 1'b0;
        end else if (w_en) begin
            r_gx    <= w_gx;
            r_gy    <= w_gy;
            r_v1    <= r_v0;
            r_last1 <= r_last0;
            r_eof1  <= r_eof0;
        end
    end

    assign w_mag = mag_t'(abs_grad(32'(r_gx)) + abs_grad(32'(r_gy)));

`ifdef SOBEL_THRESH_EN
    // Compared against the unsaturated magnitude.
    assign w_pix = (w_mag >= mag_t'(thresh)) ? '1 : '0;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^thresh;
    assign w_pix = PIX_W'(sat_pix(32'(w_mag), PIX_W));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_eof   <= 1'b0;
        end else if (w_en) begin
            r_m_valid <= r_v1;
            r_m_data  <= r_v1 ? w_pix : '0;
            r_m_last  <= r_v1 & r_last1;
            r_m_eof   <= r_v1 & r_eof1;
        end
    end

    assign bus.s_ready = w_en;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_last  = r_m_last;
    assign bus.m_eof   = r_m_eof;

endmodule
